bus_grant_ctrl: RTL

BUS_GRANT_CTRL -- requirements
Module: bus_grant_ctrl

---
 rtl/bus_grant_ctrl_pkg.sv | 23 ++
 rtl/bus_grant_ctrl_gnt_onehot_enc.sv | 18 +
 rtl/bus_grant_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bus_grant_ctrl_pkg.sv
// Shared definitions for the bus grant controller: state encoding, master count and
// the one-hot to index helper.
package bus_grant_ctrl_pkg;

  localparam int unsigned NUM_M = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StXfer    = 2'd1,
    StRelease = 2'd2
  } state_e;

  // Highest set bit wins; callers only rely on the result for one-hot inputs.
  function automatic logic [1:0] onehot_to_idx(input logic [NUM_M-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_grant_ctrl_gnt_onehot_enc.sv
// Grant vector checker/encoder: flags exactly-one, more-than-one, and the granted index.
module gnt_onehot_enc
  import bus_grant_ctrl_pkg::*;
(
  input  logic [NUM_M-1:0] gnt,
  output logic             valid,
  output logic             multi,
  output logic [1:0]       idx
);

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  always_comb begin
    multi = |(gnt & (gnt - {{(NUM_M-1){1'b0}}, 1'b1}));
    valid = (|gnt) & ~multi;
    idx   = onehot_to_idx(gnt);
  end

endmodule

// File: rtl/bus_grant_ctrl.sv
// Downstream stage of the 4-way arbiter: routes the granted master onto the shared bus,
// bounds burst length and drives the release mask back into the arbiter requests.
module bus_grant_ctrl
  import bus_grant_ctrl_pkg::*;
#(
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            gnt3,
  input  logic            gnt2,
  input  logic            gnt1,
  input  logic            gnt0,
  input  logic [3:0]      m_valid,
  input  logic [4*DW-1:0] m_data,
  input  logic [3:0]      m_last,
  output logic [3:0]      m_ready,
  output logic            bus_valid,
  output logic [DW-1:0]   bus_data,
  output logic            bus_last,
  input  logic            bus_ready,
  output logic [1:0]      bus_src,
  output logic [3:0]      rel_mask,
  output logic            gnt_err,
  output logic            timeout,
  output logic            busy
);

  localparam int unsigned CW = $clog2(MAX_BEATS + 1);

  state_e           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
  logic             gnt_err_q, gnt_err_d;
  logic             timeout_q, timeout_d;

  logic [NUM_M-1:0] gnt;
  logic [NUM_M-1:0] owner_oh;
  logic             enc_valid, enc_multi;
  logic [1:0]       enc_idx;
  logic             beat, owner_gnt, other_gnt, at_max;

  assign gnt      = {gnt3, gnt2, gnt1, gnt0};
  assign owner_oh = NUM_M'(1) << owner_q;

  gnt_onehot_enc u_enc (
    .gnt   (gnt),
    .valid (enc_valid),
    .multi (enc_multi),
    .idx   (enc_idx)
  );

  always_comb begin
    bus_valid = 1'b0;
    bus_data  = '0;
    bus_last  = 1'b0;
    m_ready   = '0;
    if (state_q == StXfer) begin
      bus_valid = m_valid[owner_q];
      bus_data  = m_data[owner_q*DW +: DW];
      bus_last  = m_last[owner_q];
      m_ready   = bus_ready ? owner_oh : '0;
    end
    rel_mask = (state_q == StRelease) ? owner_oh : '0;
    bus_src  = (state_q != StIdle) ? owner_q : 2'd0;
    busy     = (state_q != StIdle);
    gnt_err  = gnt_err_q;
    timeout  = timeout_q;
  end

  assign beat      = bus_valid & bus_ready;
  assign owner_gnt = gnt[owner_q];
  assign other_gnt = |(gnt & ~owner_oh);
  assign at_max    = (beat_cnt_q == CW'(MAX_BEATS - 1));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    gnt_err_d  = 1'b0;
    timeout_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enc_valid) begin
          owner_d    = enc_idx;
          beat_cnt_d = '0;
          state_d    = StXfer;
        end else if (enc_multi) begin
          gnt_err_d = 1'b1;
        end
      end
      StXfer: begin
        if (other_gnt) gnt_err_d = 1'b1;
        if (beat) beat_cnt_d = beat_cnt_q + CW'(1);
        // A last beat wins over both a lost grant and the length limit.
        if (beat && bus_last) begin
          state_d = StRelease;
        end else if (!owner_gnt) begin
          gnt_err_d = 1'b1;
          state_d   = StIdle;
        end else if (beat && at_max) begin
          timeout_d = 1'b1;
          state_d   = StRelease;
        end
      end
      StRelease: begin
        if (!owner_gnt) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= 2'd0;
      beat_cnt_q <= '0;
      gnt_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      gnt_err_q  <= gnt_err_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule
